cp0_intc: RTL and testbench

- Parametrised CP0 interrupt/timer unit; next generation of the single-timer CP0 register file.
- Holds Count, a configurable bank of Compare channels, Status, Cause, EPC, BadVAddr and Config.
- Synchronises N external interrupt lines and raises a registered interrupt request to the pipeline.
- Sits beside the MEM/WB stage; mtc0/mfc0 access it through the sel field, and the exception commit point drives its entry/return inputs.

---
 rtl/cp0_pkg.sv | 41 ++++
 rtl/cp0_intc_if.sv | 19 +
 rtl/cp0_timer_chan.sv | 33 +++
 rtl/cp0_intc.sv | 176 +++++++++++++++++
 tb/tb_cp0_intc.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the CP0 interrupt/timer unit.
//   Register numbers (mtc0/mfc0 rd field), ExcCodes, Status/Cause
//   bit positions, reset/constant register values and a small helper
//   that tells whether an ExcCode latches BadVAddr.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  // Status bit positions
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;

  // Cause bit positions
  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;
  localparam int CA_IP_LO  = 8;
  localparam int CA_IP_HI  = 15;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  localparam logic [31:0] STATUS_RST = 32'h0040_0000;
  localparam logic [31:0] CONFIG_VAL = 32'h0000_0001;

  // Only address-error exceptions capture the faulting address.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_intc_if.sv
// cp0_intc_if: mtc0/mfc0 access bus of the CP0 unit.
//   we/waddr/wsel/wdata : write port (master drives)
//   raddr/rsel/rdata    : read port, rdata returned by the slave
// Handshake: we is a single-cycle write strobe with no ready; the slave
// accepts every write on the clock edge where we is high. Reads have no
// strobe at all: rdata is a combinational function of raddr/rsel and the
// current register state.
interface cp0_intc_if;
  logic        we;
  logic [4:0]  waddr;
  logic [2:0]  wsel;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [2:0]  rsel;
  logic [31:0] rdata;

  modport master (output we, waddr, wsel, wdata, raddr, rsel, input rdata);
  modport slave  (input we, waddr, wsel, wdata, raddr, rsel, output rdata);
endinterface

// File: rtl/cp0_timer_chan.sv
// cp0_timer_chan: one Compare register and its sticky pending bit.
//   clk, rst  : clock, synchronous active-high reset
//   tick      : Count increments on this cycle
//   count     : current Count value
//   wr        : mtc0 to this channel's Compare
//   wdata     : write data
//   compare   : Compare register value
//   pending   : sticky match flag, cleared only by a Compare write
module cp0_timer_chan (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [31:0] count,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] compare,
  output logic        pending
);

  always_ff @(posedge clk) begin
    if (rst) begin
      compare <= '0;
      pending <= 1'b0;
    end else if (wr) begin
      // A Compare write acknowledges the interrupt and wins over a match.
      compare <= wdata;
      pending <= 1'b0;
    end else if (tick && (count == compare)) begin
      pending <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_intc.sv
// cp0_intc: CP0 interrupt/timer unit (Count, Compare bank, Status, Cause,
// EPC, BadVAddr, Config).
//   clk, rst         : clock, synchronous active-high reset
//   bus              : mtc0/mfc0 access (cp0_intc_if.slave)
//   ext_int_i        : asynchronous level interrupts -> Cause.IP[2+i]
//   exc_valid_i ...  : exception commit (code, delay slot, PC, bad address)
//   eret_i           : eret commit, clears EXL
//   int_req_o        : registered interrupt request to the pipeline
//   timer_int_o      : per-channel sticky timer pending
//   status_o/cause_o/epc_o : architectural register values
// Optional feature macro CP0_SW_INT_EN: makes Cause[9:8] software-writable
// and lets them request interrupts; without it those bits are constant 0.
import cp0_pkg::*;

module cp0_intc #(
  parameter int NUM_EXT     = 6,
  parameter int NUM_TIMERS  = 1,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_DIV   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  cp0_intc_if.slave             bus,
  input  logic [NUM_EXT-1:0]    ext_int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic                  exc_delayslot_i,
  input  logic [31:0]           exc_pc_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  eret_i,
  output logic                  int_req_o,
  output logic [NUM_TIMERS-1:0] timer_int_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  logic [31:0] count_q, status_q, epc_q, badvaddr_q;
  logic [3:0]  presc_q;
  logic        bd_q;
  logic [4:0]  exccode_q;
  logic [31:0] status_n, epc_n;
  logic [NUM_EXT-1:0] sync_q [SYNC_STAGES];
  logic [5:0]  ext_ip;
  logic [1:0]  sw_ip;
  logic [7:0]  ip;
  logic        tick, timer_any;
  logic [31:0] compare_q [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] pending;

  function automatic logic wr_hit(input logic [4:0] addr);
    return bus.we && (bus.waddr == addr) && (bus.wsel == 3'd0);
  endfunction

  // ---------------- Count and prescaler ----------------
  assign tick = (presc_q == 4'(COUNT_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      presc_q <= '0;
    end else if (wr_hit(REG_COUNT)) begin
      count_q <= bus.wdata;
      presc_q <= '0;
    end else begin
      presc_q <= tick ? 4'd0 : presc_q + 4'd1;
      if (tick) count_q <= count_q + 32'd1;
    end
  end

  // ---------------- Compare channels ----------------
  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_timer
    cp0_timer_chan u_chan (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .count   (count_q),
      .wr      (bus.we && (bus.waddr == REG_COMPARE) && (bus.wsel == 3'(g))),
      .wdata   (bus.wdata),
      .compare (compare_q[g]),
      .pending (pending[g])
    );
  end

  assign timer_any   = |pending;
  assign timer_int_o = pending;

  // ---------------- External line synchronisers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ext_int_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    ext_ip = '0;
    ext_ip[NUM_EXT-1:0] = sync_q[SYNC_STAGES-1];
  end

  // ---------------- Software interrupt bits ----------------
`ifdef CP0_SW_INT_EN
  logic [1:0] sw_ip_q;
  always_ff @(posedge clk) begin
    if (rst)                   sw_ip_q <= '0;
    else if (wr_hit(REG_CAUSE)) sw_ip_q <= bus.wdata[9:8];
  end
  assign sw_ip = sw_ip_q;
`else
  assign sw_ip = 2'b00;
`endif

  // IP7 is shared by the timer and, when NUM_EXT is 6, the last external line.
  assign ip = {ext_ip[5] | timer_any, ext_ip[4:0], sw_ip};

  // ---------------- Status / EPC / BadVAddr / Cause ----------------
  // The mtc0 value is applied first; exception entry then overwrites only
  // the fields it owns, so untouched bits keep the written data.
  always_comb begin
    status_n = wr_hit(REG_STATUS) ? bus.wdata : status_q;
    if (exc_valid_i)  status_n[ST_EXL] = 1'b1;
    else if (eret_i)  status_n[ST_EXL] = 1'b0;

    epc_n = wr_hit(REG_EPC) ? bus.wdata : epc_q;
    if (exc_valid_i) epc_n = exc_delayslot_i ? exc_pc_i - 32'd4 : exc_pc_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      badvaddr_q <= '0;
      bd_q       <= 1'b0;
      exccode_q  <= EXC_INT;
      int_req_o  <= 1'b0;
    end else begin
      status_q <= status_n;
      epc_q    <= epc_n;
      if (exc_valid_i && is_addr_exc(exc_code_i)) badvaddr_q <= exc_badvaddr_i;
      else if (wr_hit(REG_BADVADDR))              badvaddr_q <= bus.wdata;
      if (exc_valid_i) begin
        bd_q      <= exc_delayslot_i;
        exccode_q <= exc_code_i;
      end
      // Built from current state, so it falls one cycle after EXL rises.
      int_req_o <= status_q[ST_IE] & ~status_q[ST_EXL] &
                   |(ip & status_q[ST_IM_HI:ST_IM_LO]);
    end
  end

  assign status_o = status_q;
  assign epc_o    = epc_q;
  assign cause_o  = {bd_q, timer_any, 14'b0, ip, 1'b0, exccode_q, 2'b00};

  // ---------------- Read mux ----------------
  always_comb begin
    bus.rdata = '0;
    if (bus.raddr == REG_COMPARE) begin
      for (int i = 0; i < NUM_TIMERS; i++)
        if (bus.rsel == 3'(i)) bus.rdata = compare_q[i];
    end else if (bus.rsel == 3'd0) begin
      case (bus.raddr)
        REG_BADVADDR: bus.rdata = badvaddr_q;
        REG_COUNT:    bus.rdata = count_q;
        REG_STATUS:   bus.rdata = status_q;
        REG_CAUSE:    bus.rdata = cause_o;
        REG_EPC:      bus.rdata = epc_q;
        REG_CONFIG:   bus.rdata = CONFIG_VAL;
        default:      bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: directed and randomized checks for cp0_intc built with
// NUM_TIMERS=2 (other parameters at default: 6 lines, 2 sync stages,
// Count every 2 cycles). The reference model tracks Count as
// base + elapsed_cycles / COUNT_DIV and the exception registers as plain
// variables updated by the architectural rules.
module tb_cp0_intc;
  import cp0_pkg::*;

  localparam int DIV = 2;

  logic        clk, rst;
  logic [5:0]  ext_int_i;
  logic        exc_valid_i, exc_delayslot_i, eret_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i, exc_badvaddr_i;
  logic        int_req_o;
  logic [1:0]  timer_int_o;
  logic [31:0] status_o, cause_o, epc_o;

  cp0_intc_if bus ();

  cp0_intc #(.NUM_EXT(6), .NUM_TIMERS(2), .SYNC_STAGES(2), .COUNT_DIV(DIV)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .ext_int_i       (ext_int_i),
    .exc_valid_i     (exc_valid_i),
    .exc_code_i      (exc_code_i),
    .exc_delayslot_i (exc_delayslot_i),
    .exc_pc_i        (exc_pc_i),
    .exc_badvaddr_i  (exc_badvaddr_i),
    .eret_i          (eret_i),
    .int_req_o       (int_req_o),
    .timer_int_o     (timer_int_o),
    .status_o        (status_o),
    .cause_o         (cause_o),
    .epc_o           (epc_o)
  );

  // ---------------- clock / cycle counter ----------------
  int unsigned cyc;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h expected <empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    bus.we = 1'b1; bus.waddr = a; bus.wsel = s; bus.wdata = d;
    step(1);
    bus.we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [2:0] s, output logic [31:0] d);
    bus.raddr = a; bus.rsel = s;
    #1;
    d = bus.rdata;
  endtask

  task automatic exc_pulse(input logic [4:0] code, input logic ds,
                           input logic [31:0] pc, input logic [31:0] bad);
    exc_valid_i = 1'b1; exc_code_i = code; exc_delayslot_i = ds;
    exc_pc_i = pc; exc_badvaddr_i = bad;
    step(1);
    exc_valid_i = 1'b0;
  endtask

  task automatic eret_pulse();
    eret_i = 1'b1;
    step(1);
    eret_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] d;
  logic [31:0] m_cnt_base, m_status, m_epc, m_badv;
  int unsigned m_cnt_cyc;
  logic [4:0]  m_code;
  logic        m_bd;

  initial begin
    rst = 1'b1;
    ext_int_i = '0; exc_valid_i = 0; exc_delayslot_i = 0; eret_i = 0;
    exc_code_i = '0; exc_pc_i = '0; exc_badvaddr_i = '0;
    bus.we = 0; bus.waddr = '0; bus.wsel = '0; bus.wdata = '0;
    bus.raddr = '0; bus.rsel = '0;

    // Reset state
    step(3);
    check("rst_status", status_o, 32'h0040_0000);
    check("rst_cause", cause_o, 32'h0);
    check("rst_epc", epc_o, 32'h0);
    check("rst_int_req", {31'b0, int_req_o}, 32'h0);
    check("rst_timer_int", {30'b0, timer_int_o}, 32'h0);
    rd(REG_COUNT, 0, d);    check("rst_count", d, 32'h0);
    rd(REG_BADVADDR, 0, d); check("rst_badvaddr", d, 32'h0);
    rd(REG_CONFIG, 0, d);   check("config", d, 32'h1);
    rst = 1'b0;
    step(1);

    // Count wrap with prescaler
    mtc0(REG_COUNT, 0, 32'hFFFF_FFFE);
    rd(REG_COUNT, 0, d); check("cnt_load", d, 32'hFFFF_FFFE);
    step(2); rd(REG_COUNT, 0, d); check("cnt_plus1", d, 32'hFFFF_FFFF);
    step(2); rd(REG_COUNT, 0, d); check("cnt_wrap", d, 32'h0);

    // Timer channel 1 match; channel 0 parked far away
    mtc0(REG_COMPARE, 0, 32'h1000);
    mtc0(REG_COMPARE, 1, 32'h5);
    rd(REG_COMPARE, 1, d); check("cmp1_read", d, 32'h5);
    rd(REG_COMPARE, 2, d); check("cmp2_read0", d, 32'h0);
    mtc0(REG_COUNT, 0, 32'h0);
    step(11);
    rd(REG_COUNT, 0, d); check("cnt_at5", d, 32'h5);
    check("pend_before", {30'b0, timer_int_o}, 32'h0);
    step(1);
    check("pend_set", {30'b0, timer_int_o}, 32'h2);
    check("cause_ti", {31'b0, cause_o[CA_TI]}, 32'h1);
    check("cause_ip7", {31'b0, cause_o[15]}, 32'h1);
    step(3);
    check("pend_sticky", {30'b0, timer_int_o}, 32'h2);
    mtc0(REG_COMPARE, 1, 32'h100);
    check("pend_clr", {30'b0, timer_int_o}, 32'h0);
    check("cause_ti_clr", {31'b0, cause_o[CA_TI]}, 32'h0);

    // External line -> Cause.IP2 -> int_req, then exception masks it
    mtc0(REG_STATUS, 0, 32'h0000_0401);
    ext_int_i = 6'b000001;
    step(1); check("ip2_early", {31'b0, cause_o[10]}, 32'h0);
    step(1); check("ip2_set", {31'b0, cause_o[10]}, 32'h1);
    check("int_req_early", {31'b0, int_req_o}, 32'h0);
    step(1); check("int_req_set", {31'b0, int_req_o}, 32'h1);
    exc_pulse(EXC_INT, 0, 32'h8000_0200, 32'h0000_FFFF);
    check("exl_set", {31'b0, status_o[ST_EXL]}, 32'h1);
    check("epc_int", epc_o, 32'h8000_0200);
    step(1); check("int_req_drop", {31'b0, int_req_o}, 32'h0);
    rd(REG_BADVADDR, 0, d); check("badv_kept_int", d, 32'h0);
    ext_int_i = '0;
    eret_pulse();
    check("eret_exl", {31'b0, status_o[ST_EXL]}, 32'h0);
    step(2);

    // Address error in a delay slot
    exc_pulse(EXC_ADEL, 1, 32'hBFC0_0104, 32'h0000_1233);
    check("epc_ds", epc_o, 32'hBFC0_0100);
    check("cause_bd_code", cause_o & 32'h8000_007C, 32'h8000_0010);
    rd(REG_BADVADDR, 0, d); check("badv_adel", d, 32'h0000_1233);
    exc_pulse(EXC_INT, 0, 32'h0000_0100, 32'h0000_AAAA);
    rd(REG_BADVADDR, 0, d); check("badv_kept", d, 32'h0000_1233);
    check("cause_nobd", cause_o & 32'h8000_007C, 32'h0);

    // Exception vs eret vs mtc0 EPC in the same cycle
    eret_pulse();
    check("exl_clear", {31'b0, status_o[ST_EXL]}, 32'h0);
    bus.we = 1; bus.waddr = REG_EPC; bus.wsel = 0; bus.wdata = 32'h0000_DEAD;
    eret_i = 1;
    exc_pulse(EXC_INT, 0, 32'h8000_1000, 32'h0);
    bus.we = 0; eret_i = 0;
    check("prio_exl", {31'b0, status_o[ST_EXL]}, 32'h1);
    check("prio_epc", epc_o, 32'h8000_1000);

    // Software interrupt bits
    mtc0(REG_STATUS, 0, 32'h0000_0301);
    mtc0(REG_CAUSE, 0, 32'h0000_0300);
    step(1);
`ifdef CP0_SW_INT_EN
    check("sw_ip", {30'b0, cause_o[9:8]}, 32'h3);
    check("sw_int_req", {31'b0, int_req_o}, 32'h1);
`else
    check("sw_ip", {30'b0, cause_o[9:8]}, 32'h0);
    check("sw_int_req", {31'b0, int_req_o}, 32'h0);
`endif
    mtc0(REG_CAUSE, 0, 32'h0);
    mtc0(REG_STATUS, 0, 32'h0);

    // Ignored writes and unmapped reads
    mtc0(REG_CONFIG, 0, 32'hFFFF_FFFF);
    rd(REG_CONFIG, 0, d);   check("config_ro", d, 32'h1);
    mtc0(REG_STATUS, 1, 32'hFFFF_FFFF);
    check("status_sel1_ign", status_o, 32'h0);
    rd(REG_STATUS, 1, d);   check("status_sel1_rd", d, 32'h0);
    rd(5'd20, 0, d);        check("unmapped_rd", d, 32'h0);

    // Randomized phase: model seeded from a known state
    mtc0(REG_STATUS, 0, 32'h0);       m_status = 32'h0;
    mtc0(REG_EPC, 0, 32'h0);          m_epc    = 32'h0;
    mtc0(REG_BADVADDR, 0, 32'h0);     m_badv   = 32'h0;
    exc_pulse(EXC_INT, 0, 32'h0, 32'h0);
    m_status = 32'h2; m_code = 5'd0; m_bd = 1'b0;
    mtc0(REG_COUNT, 0, 32'h1234_0000);
    m_cnt_base = 32'h1234_0000; m_cnt_cyc = cyc;

    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          logic [31:0] v;
          v = $urandom;
          mtc0(REG_COUNT, 0, v);
          m_cnt_base = v; m_cnt_cyc = cyc;
        end
        1: begin
          logic [4:0]  code, wreg;
          logic        ds, sim_w;
          logic [31:0] pc, bad, wv;
          int r;
          r = $urandom_range(0, 3);
          code = (r == 0) ? 5'd0 : (r == 1) ? 5'd4 : (r == 2) ? 5'd5 : 5'($urandom_range(0, 31));
          ds = 1'($urandom_range(0, 1));
          pc = $urandom; bad = $urandom; wv = $urandom;
          sim_w = 1'($urandom_range(0, 1));
          r = $urandom_range(0, 2);
          wreg = (r == 0) ? REG_EPC : (r == 1) ? REG_BADVADDR : REG_STATUS;
          if (sim_w) begin
            bus.we = 1; bus.waddr = wreg; bus.wsel = 0; bus.wdata = wv;
            if (wreg == REG_EPC)      m_epc = wv;
            if (wreg == REG_BADVADDR) m_badv = wv;
            if (wreg == REG_STATUS)   m_status = wv;
          end
          exc_pulse(code, ds, pc, bad);
          bus.we = 0;
          m_status = m_status | 32'h2;
          m_epc = ds ? pc - 32'd4 : pc;
          if (code == 5'd4 || code == 5'd5) m_badv = bad;
          m_code = code; m_bd = ds;
        end
        2: begin
          logic [31:0] v;
          v = $urandom;
          mtc0(REG_STATUS, 0, v);
          m_status = v;
        end
        default: begin
          eret_pulse();
          m_status = m_status & ~32'h2;
        end
      endcase
      step($urandom_range(0, 3));

      exp_q.push_back(m_cnt_base + (cyc - m_cnt_cyc) / DIV);
      exp_q.push_back(m_status);
      exp_q.push_back(m_epc);
      exp_q.push_back(m_badv);
      exp_q.push_back({m_bd, 24'h0, m_code, 2'b00});
      rd(REG_COUNT, 0, d);    sb_check("rnd_count", d);
      rd(REG_STATUS, 0, d);   sb_check("rnd_status", d);
      rd(REG_EPC, 0, d);      sb_check("rnd_epc", d);
      rd(REG_BADVADDR, 0, d); sb_check("rnd_badv", d);
      rd(REG_CAUSE, 0, d);    sb_check("rnd_cause", d & 32'h8000_007C);
    end

    // Reset in the middle of a write overrides it
    step(1);
    rst = 1'b1;
    bus.we = 1; bus.waddr = REG_EPC; bus.wsel = 0; bus.wdata = 32'h5555_AAAA;
    step(1);
    bus.we = 0;
    check("midrst_epc", epc_o, 32'h0);
    check("midrst_status", status_o, 32'h0040_0000);
    rd(REG_COUNT, 0, d); check("midrst_count", d, 32'h0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
